// File: rtl/mem_bus_arb_pkg.sv
// Shared types and default widths for the two-master memory bus arbiter.
// Round-robin tie-breaking is enabled by defining MEM_BUS_ARB_ROUND_ROBIN_EN.
package mem_bus_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arb_pick.sv
// Winner selection between the data port (req0) and the fetch port (req1).
// With MEM_BUS_ARB_ROUND_ROBIN_EN a last-grant flop alternates ties; otherwise m0 always wins.
module mem_bus_arb_pick (
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic reset,
    input  logic grant_en,
`endif
    input  logic req0,
    input  logic req1,
    output logic winner
);

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    logic last_q;
    logic last_d;

    // Starting at 1 means "m1 was granted last", so m0 takes the first tie.
    always_comb begin
        winner = req1 && !req0;
        if (req0 && req1) begin
            winner = !last_q;
        end
        last_d = grant_en ? winner : last_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign winner = req1 && !req0;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master to one-slave memory bus arbiter with IDLE/BUS/RDATA sequencing.
// Tie-break policy is chosen by MEM_BUS_ARB_ROUND_ROBIN_EN (see mem_bus_arb_pick).
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata
);

    arb_state_t          state_q, state_d;
    logic                grant_q, grant_d;
    logic                pick_winner;
    logic                m0_req, m1_req;
    logic                own_read, own_write, own_req;
    logic [ADDR_W-1:0]   own_address;
    logic [DATA_W-1:0]   own_writedata;
    logic [DATA_W/8-1:0] own_byteenable;
    logic                in_bus, accept, rdata_cycle;

    assign m0_req = m0_read || m0_write;
    assign m1_req = m1_read || m1_write;

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    logic grant_en;
    assign grant_en = (state_q == IDLE) && (m0_req || m1_req);
`endif

    mem_bus_arb_pick u_pick (
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
        .clk      (clk),
        .reset    (reset),
        .grant_en (grant_en),
`endif
        .req0     (m0_req),
        .req1     (m1_req),
        .winner   (pick_winner)
    );

    always_comb begin
        own_read       = grant_q ? m1_read       : m0_read;
        own_write      = grant_q ? m1_write      : m0_write;
        own_address    = grant_q ? m1_address    : m0_address;
        own_writedata  = grant_q ? m1_writedata  : m0_writedata;
        own_byteenable = grant_q ? m1_byteenable : m0_byteenable;
    end

    assign own_req     = own_read || own_write;
    assign in_bus      = (state_q == BUS);
    assign accept      = in_bus && own_req && !s_waitrequest;
    assign rdata_cycle = (state_q == RDATA);

    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no latch is inferred.
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = BUS;
                    grant_d = pick_winner;
                end
            end
            BUS: begin
                // A write wins over a simultaneous read, so it never enters RDATA.
                if (!own_req) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    state_d = own_write ? IDLE : RDATA;
                end
            end
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    assign s_address    = in_bus ? own_address    : '0;
    assign s_writedata  = in_bus ? own_writedata  : '0;
    assign s_byteenable = in_bus ? own_byteenable : '0;
    assign s_read       = in_bus && own_read && !own_write;
    assign s_write      = in_bus && own_write;

    assign m0_waitrequest   = !(accept && !grant_q);
    assign m1_waitrequest   = !(accept && grant_q);
    assign m0_readdatavalid = rdata_cycle && !grant_q;
    assign m1_readdatavalid = rdata_cycle && grant_q;
    assign m0_readdata      = m0_readdatavalid ? s_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? s_readdata : '0;

endmodule
